// File: rtl/ctrl_pkg.sv
// Shared control definitions for the permutation-datapath sequencers:
// FSM state encoding and default sizing constants reused by the stage controllers.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    localparam int DEF_NSTAGES    = 4;
    localparam int DEF_NROUNDS    = 24;
    localparam int DEF_WDT_CYCLES = 1024;

endpackage

// File: rtl/round_scheduler_if.sv
// Control bus between the round scheduler (slave modport) and its environment (master modport).
// Handshake: start is a level sampled only while idle; stage_start is a one-cycle one-hot launch; stage_done is sampled only in WAIT.
interface round_scheduler_if #(
    parameter int NSTAGES = 4,
    parameter int RW      = 5,
    parameter int SW      = 2
);
    import ctrl_pkg::*;

    logic               start;
    logic               abort;
    logic [NSTAGES-1:0] stage_done;
    logic [NSTAGES-1:0] stage_start;
    logic [SW-1:0]      mem_sel;
    logic               mem_grant;
    logic [RW-1:0]      round_idx;
    logic               busy;
    logic               ok;
    logic               error;
    state_t             state;

    modport master (
        output start, abort, stage_done,
        input  stage_start, mem_sel, mem_grant, round_idx, busy, ok, error, state
    );

    modport slave (
        input  start, abort, stage_done,
        output stage_start, mem_sel, mem_grant, round_idx, busy, ok, error, state
    );

endinterface

// File: rtl/round_stage_counter.sv
// Nested stage/round counter: stage wraps to 0 and bumps round on inc; clr restarts both.
module round_stage_counter #(
    parameter int NSTAGES = 4,
    parameter int NROUNDS = 24,
    parameter int RW      = 5,
    parameter int SW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [SW-1:0] stage,
    output logic [RW-1:0] round,
    output logic          last_stage,
    output logic          last_round
);

    assign last_stage = (stage == SW'(NSTAGES - 1));
    assign last_round = (round == RW'(NROUNDS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage <= '0;
            round <= '0;
        end else if (clr) begin
            stage <= '0;
            round <= '0;
        end else if (inc) begin
            if (last_stage) begin
                stage <= '0;
                round <= round + RW'(1);
            end else begin
                stage <= stage + SW'(1);
            end
        end
    end

endmodule

// File: rtl/round_scheduler.sv
// Round scheduler: runs NSTAGES stage controllers in order for NROUNDS rounds and owns the lane-memory port.
// Optional stage watchdog is built when ROUND_SCHED_WATCHDOG_EN is defined.
module round_scheduler
    import ctrl_pkg::*;
#(
    parameter int NSTAGES    = DEF_NSTAGES,
    parameter int NROUNDS    = DEF_NROUNDS,
    parameter int RW         = 5,
    parameter int SW         = 2,
    parameter int WDT_CYCLES = DEF_WDT_CYCLES
) (
    input logic              clk,
    input logic              rst,
    round_scheduler_if.slave bus
);

    if (NSTAGES < 2 || NSTAGES > (1 << SW)) begin : g_bad_nstages
        $error("round_scheduler: NSTAGES must be in 2..2**SW");
    end
    if (NROUNDS < 1 || NROUNDS > (1 << RW)) begin : g_bad_nrounds
        $error("round_scheduler: NROUNDS must be in 1..2**RW");
    end
    if (WDT_CYCLES < 2) begin : g_bad_wdt
        $error("round_scheduler: WDT_CYCLES must be at least 2");
    end

    state_t             state;
    logic [NSTAGES-1:0] launch_q;
    logic               grant_q;
    logic               busy_q;
    logic               ok_q;

    logic [SW-1:0] stage;
    logic [SW-1:0] next_stage;
    logic [RW-1:0] round;
    logic          last_stage;
    logic          last_round;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          done_sel;

    // Only the selected stage's done bit matters; the others are masked here.
    assign done_sel   = bus.stage_done[stage];
    assign next_stage = last_stage ? '0 : stage + SW'(1);
    assign cnt_clr    = (state == ST_IDLE) && bus.start;
    assign cnt_inc    = (state == ST_ADVANCE) && !bus.abort && !(last_stage && last_round);

    round_stage_counter #(
        .NSTAGES (NSTAGES),
        .NROUNDS (NROUNDS),
        .RW      (RW),
        .SW      (SW)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .inc        (cnt_inc),
        .clr        (cnt_clr),
        .stage      (stage),
        .round      (round),
        .last_stage (last_stage),
        .last_round (last_round)
    );

`ifdef ROUND_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(WDT_CYCLES);
    logic [WDW-1:0] wdt;
    logic           err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            launch_q <= '0;
            grant_q  <= 1'b0;
            busy_q   <= 1'b0;
            ok_q     <= 1'b0;
`ifdef ROUND_SCHED_WATCHDOG_EN
            wdt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            launch_q <= '0;
            ok_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_LAUNCH;
                        launch_q <= NSTAGES'(1);
                        grant_q  <= 1'b1;
                        busy_q   <= 1'b1;
`ifdef ROUND_SCHED_WATCHDOG_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                ST_LAUNCH: begin
                    if (bus.abort) begin
                        state   <= ST_IDLE;
                        grant_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
`ifdef ROUND_SCHED_WATCHDOG_EN
                        wdt   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (bus.abort) begin
                        state   <= ST_IDLE;
                        grant_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (done_sel) begin
                        state   <= ST_ADVANCE;
                        grant_q <= 1'b0;
`ifdef ROUND_SCHED_WATCHDOG_EN
                    end else if (wdt == WDW'(WDT_CYCLES - 1)) begin
                        state   <= ST_IDLE;
                        grant_q <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wdt <= wdt + WDW'(1);
`endif
                    end
                end
                ST_ADVANCE: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (last_stage && last_round) begin
                        state <= ST_FINISH;
                        ok_q  <= 1'b1;
                    end else begin
                        state    <= ST_LAUNCH;
                        launch_q <= NSTAGES'(1) << next_stage;
                        grant_q  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stage_start = launch_q;
    assign bus.mem_sel     = stage;
    assign bus.mem_grant   = grant_q;
    assign bus.round_idx   = round;
    assign bus.busy        = busy_q;
    assign bus.ok          = ok_q;
    assign bus.state       = state;
`ifdef ROUND_SCHED_WATCHDOG_EN
    assign bus.error       = err_q;
`else
    assign bus.error       = 1'b0;
`endif

endmodule

// File: tb/tb_round_scheduler.sv
// Directed bench for round_scheduler (NSTAGES=4, NROUNDS=2, WDT_CYCLES=16): vector table plus hand sequences.
// The watchdog sequence is compiled only when ROUND_SCHED_WATCHDOG_EN is defined.
module tb_round_scheduler;
    import ctrl_pkg::*;

    localparam int NS = 4;
    localparam int NR = 2;

    typedef struct {
        logic       start;
        logic       abort;
        logic [3:0] done;
        state_t     st;
        logic [3:0] ss;
        logic [1:0] sel;
        logic       grant;
        logic [4:0] rnd;
        logic       busy;
        logic       ok;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic sb_en;
    logic [NS-1:0] exp_q[$];
    vec_t vecs[$];

    round_scheduler_if #(.NSTAGES(NS), .RW(5), .SW(2)) bus();

    round_scheduler #(
        .NSTAGES    (NS),
        .NROUNDS    (NR),
        .RW         (5),
        .SW         (2),
        .WDT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard for launch pulses
    always @(negedge clk) begin
        if (sb_en && bus.stage_start != '0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_launch: got %b, none expected", bus.stage_start);
            end else begin
                logic [NS-1:0] e;
                e = exp_q.pop_front();
                if (e !== bus.stage_start) begin
                    n_errors++;
                    $display("FAIL sb_launch: got %b want %b", bus.stage_start, e);
                end
            end
        end
    end

    task automatic step(input logic s, input logic a, input logic [3:0] d);
        bus.start      = s;
        bus.abort      = a;
        bus.stage_done = d;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic add(input logic s, input logic a, input logic [3:0] d, input state_t st,
                       input logic [3:0] ss, input logic [1:0] sel, input logic g,
                       input logic [4:0] r, input logic b, input logic o);
        vec_t v;
        v.start = s; v.abort = a; v.done = d; v.st = st; v.ss = ss;
        v.sel = sel; v.grant = g; v.rnd = r; v.busy = b; v.ok = o;
        vecs.push_back(v);
    endtask

    // Three rows of a stage that completes in its first WAIT cycle, starting from LAUNCH.
    task automatic add_stage(input int r, input int s);
        int ns;
        int nr;
        ns = (s == NS - 1) ? 0 : s + 1;
        nr = (s == NS - 1) ? r + 1 : r;
        add(0, 0, 4'b0000, ST_WAIT, 4'b0000, 2'(s), 1, 5'(r), 1, 0);
        add(0, 0, 4'(1 << s), ST_ADVANCE, 4'b0000, 2'(s), 0, 5'(r), 1, 0);
        if (r == NR - 1 && s == NS - 1)
            add(0, 0, 4'b0000, ST_FINISH, 4'b0000, 2'(s), 0, 5'(r), 1, 1);
        else
            add(0, 0, 4'b0000, ST_LAUNCH, 4'(1 << ns), 2'(ns), 1, 5'(nr), 1, 0);
    endtask

    initial begin
        int grant_cnt;
        n_checks = 0;
        n_errors = 0;
        sb_en = 1'b0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.stage_done = '0;

        // full run of two rounds, then idle hold
        add(1, 0, 4'b0000, ST_LAUNCH, 4'b0001, 0, 1, 0, 1, 0);
        for (int r = 0; r < NR; r++)
            for (int s = 0; s < NS; s++)
                add_stage(r, s);
        add(0, 0, 4'b0000, ST_IDLE, 4'b0000, 3, 0, 1, 0, 0);
        add(0, 1, 4'b0000, ST_IDLE, 4'b0000, 3, 0, 1, 0, 0);
        // done bits all high: no skipping, unselected bits ignored, abort beats done
        add(1, 0, 4'b1111, ST_LAUNCH, 4'b0001, 0, 1, 0, 1, 0);
        add(0, 0, 4'b1111, ST_WAIT, 4'b0000, 0, 1, 0, 1, 0);
        add(0, 0, 4'b1111, ST_ADVANCE, 4'b0000, 0, 0, 0, 1, 0);
        add(0, 0, 4'b1111, ST_LAUNCH, 4'b0010, 1, 1, 0, 1, 0);
        add(0, 0, 4'b1101, ST_WAIT, 4'b0000, 1, 1, 0, 1, 0);
        add(0, 0, 4'b1101, ST_WAIT, 4'b0000, 1, 1, 0, 1, 0);
        add(0, 0, 4'b1101, ST_WAIT, 4'b0000, 1, 1, 0, 1, 0);
        add(0, 1, 4'b0010, ST_IDLE, 4'b0000, 1, 0, 0, 0, 0);
        // abort in WAIT of round 1 stage 3, then restart and abort corners
        add(1, 0, 4'b0000, ST_LAUNCH, 4'b0001, 0, 1, 0, 1, 0);
        for (int i = 0; i < NS + 3; i++)
            add_stage(i / NS, i % NS);
        add(0, 0, 4'b0000, ST_WAIT, 4'b0000, 3, 1, 1, 1, 0);
        add(0, 0, 4'b0000, ST_WAIT, 4'b0000, 3, 1, 1, 1, 0);
        add(0, 1, 4'b1000, ST_IDLE, 4'b0000, 3, 0, 1, 0, 0);
        add(0, 0, 4'b0000, ST_IDLE, 4'b0000, 3, 0, 1, 0, 0);
        add(1, 0, 4'b0000, ST_LAUNCH, 4'b0001, 0, 1, 0, 1, 0);
        add(0, 1, 4'b0000, ST_IDLE, 4'b0000, 0, 0, 0, 0, 0);
        add(1, 1, 4'b0000, ST_LAUNCH, 4'b0001, 0, 1, 0, 1, 0);
        add(1, 0, 4'b0000, ST_WAIT, 4'b0000, 0, 1, 0, 1, 0);
        add(1, 0, 4'b0001, ST_ADVANCE, 4'b0000, 0, 0, 0, 1, 0);
        add(0, 1, 4'b0000, ST_IDLE, 4'b0000, 0, 0, 0, 0, 0);

        // reset state
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.mem_grant, 0);
        check("rst_start", bus.stage_start, 0);
        check("rst_ok", bus.ok, 0);
        check("rst_err", bus.error, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].abort, vecs[i].done);
            n_checks++;
            if (bus.state !== vecs[i].st || bus.stage_start !== vecs[i].ss ||
                bus.mem_sel !== vecs[i].sel || bus.mem_grant !== vecs[i].grant ||
                bus.round_idx !== vecs[i].rnd || bus.busy !== vecs[i].busy ||
                bus.ok !== vecs[i].ok || bus.error !== 1'b0) begin
                n_errors++;
                $display("FAIL vec%0d: got st=%0d ss=%b sel=%0d gnt=%b rnd=%0d busy=%b ok=%b err=%b want st=%0d ss=%b sel=%0d gnt=%b rnd=%0d busy=%b ok=%b err=0",
                         i, bus.state, bus.stage_start, bus.mem_sel, bus.mem_grant, bus.round_idx,
                         bus.busy, bus.ok, bus.error, vecs[i].st, vecs[i].ss, vecs[i].sel,
                         vecs[i].grant, vecs[i].rnd, vecs[i].busy, vecs[i].ok);
            end
        end

        // stage 2 stalls: done low for 10 cycles, asserted in its 10th WAIT cycle
        sb_en = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        step(1, 0, 4'b0000);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0001);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0010);
        step(0, 0, 4'b0000);
        grant_cnt = 0;
        while (bus.mem_grant && bus.mem_sel == 2'd2 && grant_cnt < 40) begin
            grant_cnt++;
            step(0, 0, (grant_cnt == 11) ? 4'b0100 : 4'b0000);
        end
        check("stall_grant_cycles", grant_cnt, 11);
        check("stall_bubble_grant", bus.mem_grant, 0);
        check("stall_bubble_state", bus.state, ST_ADVANCE);
        step(0, 0, 4'b0000);
        check("stall_next_launch", bus.stage_start, 4'b1000);
        step(0, 1, 4'b0000);
        sb_en = 1'b0;
        check("sb_drained", exp_q.size(), 0);

        // asynchronous reset between edges while in WAIT of stage 1
        step(1, 0, 4'b0000);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0001);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0000);
        check("pre_rst_sel", bus.mem_sel, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_state", bus.state, ST_IDLE);
        check("arst_busy", bus.busy, 0);
        check("arst_grant", bus.mem_grant, 0);
        check("arst_sel", bus.mem_sel, 0);
        check("arst_rnd", bus.round_idx, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 4'b0000);
        check("post_rst_launch", bus.stage_start, 4'b0001);
        check("post_rst_state", bus.state, ST_LAUNCH);
        step(0, 1, 4'b0000);

`ifdef ROUND_SCHED_WATCHDOG_EN
        begin
            int   n_wait;
            logic ok_seen;
            step(1, 0, 4'b0000);
            step(0, 0, 4'b0000);
            step(0, 0, 4'b0001);
            step(0, 0, 4'b0000);
            check("wd_launch_s1", bus.stage_start, 4'b0010);
            step(0, 0, 4'b0000);
            n_wait = 0;
            ok_seen = 1'b0;
            while (bus.state == ST_WAIT && n_wait < 100) begin
                n_wait++;
                if (bus.ok) ok_seen = 1'b1;
                step(0, 0, 4'b0000);
            end
            check("wd_wait_cycles", n_wait, 16);
            check("wd_state", bus.state, ST_IDLE);
            check("wd_error", bus.error, 1);
            check("wd_no_ok", ok_seen | bus.ok, 0);
            step(1, 0, 4'b0000);
            check("wd_error_clr", bus.error, 0);
            check("wd_restart", bus.state, ST_LAUNCH);
            step(0, 1, 4'b0000);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/round_scheduler.md
Name: round_scheduler

Overview:
- Top-level sequencer for the 5x5-lane permutation datapath.
- Runs NSTAGES stage controllers (e.g. line-load, shift/rotate, arithmetic, store) in fixed order for NROUNDS rounds.
- Uses a one-hot start pulse and a per-stage done handshake for each stage.
- Owns the single lane-memory port: selects which stage drives it and inserts a handover bubble between stages.

Parameters:
- NSTAGES, 4, number of stage controllers sequenced per round (2..8).
- NROUNDS, 24, rounds per run (1..2^RW).
- RW, 5, width of round counter and round_idx.
- SW, 2, width of stage index; must satisfy 2^SW >= NSTAGES.
- WDT_CYCLES, 1024, watchdog limit in cycles per stage (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  cancel the run; honoured in LAUNCH, WAIT and ADVANCE.
- stage_done  input  NSTAGES  per-stage completion pulse or level.
- stage_start  output  NSTAGES  one-hot, one-cycle launch pulse.
- mem_sel  output  SW  index of the stage that owns the lane-memory port.
- mem_grant  output  1  memory-port ownership valid.
- round_idx  output  RW  current round number, 0-based.
- busy  output  1  high in every state except IDLE.
- ok  output  1  one-cycle pulse when all rounds complete.
- error  output  1  sticky watchdog flag (optional feature only).

Behaviour:
- Reset: clock and reset are fixed as one clock, asynchronous active-low reset.
  - rst low forces state to IDLE and clears the stage counter, round counter, watchdog counter and error.
  - All outputs are 0 during and after reset.
  - Reset mid-run abandons the run immediately; no ok pulse is produced.
- States: IDLE, LAUNCH, WAIT, ADVANCE, FINISH.
- IDLE:
  - busy=0, mem_grant=0.
  - start=1 → LAUNCH, with stage=0 and round=0.
- LAUNCH (1 cycle):
  - stage_start[stage]=1, mem_grant=1, mem_sel=stage.
  - Next state WAIT.
- WAIT:
  - mem_grant=1, mem_sel=stage.
  - stage_done[stage]=1 → ADVANCE.
  - stage_done bits of non-selected stages are ignored.
- ADVANCE (1 cycle):
  - mem_grant=0; this is the handover bubble.
  - If stage<NSTAGES-1: stage+1, go to LAUNCH.
  - Else if round<NROUNDS-1: round+1, stage=0, go to LAUNCH.
  - Else go to FINISH.
- FINISH (1 cycle):
  - ok=1, busy=1.
  - Next state IDLE; round_idx holds NROUNDS-1 until the next start.
- Latency:
  - start sampled at edge k → stage_start[0] high in cycle k+1.
  - stage_done sampled in WAIT at edge t → next stage_start high at edge t+2.
  - Minimum per-stage cost is 3 cycles.
- stage_done asserted during LAUNCH is not sampled; every stage takes at least one WAIT cycle.
- start while busy is ignored.
- start and abort together in IDLE: start wins.
- abort has priority over stage_done in the same cycle; it goes to IDLE with no ok and counters held.
- Counters wrap only through explicit reset to 0.
  - No arithmetic overflow is possible given RW sizing.
  - Elaboration asserts NROUNDS <= 2^RW and NSTAGES <= 2^SW.

Optional Feature:
- Macro: ROUND_SCHED_WATCHDOG_EN.
- Defined:
  - A counter clears in LAUNCH and increments each WAIT cycle.
  - If it reaches WDT_CYCLES-1 without stage_done, error is set (sticky), no ok is produced, and the FSM goes to IDLE.
  - error clears on the next accepted start.
- Undefined: no counter is built and error is tied to 0.

Decomposition:
- Shared package ctrl_pkg:
  - state encoding localparams (IDLE=0, LAUNCH=1, WAIT=2, ADVANCE=3, FINISH=4);
  - default NSTAGES, NROUNDS and WDT_CYCLES constants, reused by the stage controllers.
- One sub-module: round_stage_counter.
  - Nested stage/round counter with inc, clr, last_stage and last_round outputs.
  - Reset is asynchronous active-low.

Test Plan:
- NSTAGES=4, NROUNDS=2, each stage_done pulsed in its first WAIT cycle.
  - stage_start sequence 1,2,4,8,1,2,4,8, each 3 cycles apart.
  - ok high exactly 25 cycles after start.
  - round_idx goes 0 → 1 after the 4th ADVANCE.
- Stage 2 holds done low for 10 cycles.
  - mem_sel=2 and mem_grant=1 for 11 cycles, then mem_grant=0 for 1 cycle.
  - Then stage_start=8.
- stage_done=4'b1111 held constant in WAIT of stage 0.
  - Only stage 0 advances per pass; other bits have no effect until their stage is selected.
- abort asserted in WAIT of round 1, stage 3.
  - Next cycle: IDLE, busy=0, no ok.
  - A later start restarts at round 0, stage 0.
- rst driven low mid-WAIT, asynchronously between edges.
  - All outputs are 0 immediately.
  - After release, start=1 gives stage_start=1 on the next cycle.
- With ROUND_SCHED_WATCHDOG_EN and WDT_CYCLES=16, stage 1 never completes.
  - error=1 and FSM in IDLE after 16 WAIT cycles; no ok.
  - The next start clears error.
